// File: rtl/wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pkg
// Shared constants and types for the MEM/WB writeback stage.
//   WB_SEL_*  : writeback source select codes (ALU, LOAD, PC+4, reserved)
//   F3_*      : load funct3 encodings (lb, lh, lw, lbu, lhu)
//   wb_slot_t : contents of one captured MEM/WB pipeline slot
// -----------------------------------------------------------------------------
package wb_stage_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_RSVD = 2'd3;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef struct packed {
    logic        valid;
    logic        wr_en;
    logic [4:0]  rd;
    logic [1:0]  wb_sel;
    logic [2:0]  ld_funct3;
    logic [31:0] alu_res;
    logic [31:0] ld_data;
    logic [31:0] pc4;
  } wb_slot_t;

endpackage

// File: rtl/wb_stage_if.sv
// -----------------------------------------------------------------------------
// wb_stage_if
// Bundle between the MEM stage / hazard unit (master) and the writeback stage
// (slave).
//   MEM side : valid/wr_en/rd/wb_sel/ld_funct3/alu_res/ld_data/pc4 (*_mem_i)
//   control  : stall_wb_i, flush_wb_i
//   results  : regfile write port, forwarding valid, retire, load error,
//              retired-instruction count (CNT_W bits)
// -----------------------------------------------------------------------------
interface wb_stage_if #(
  parameter int CNT_W = 64
);
  logic             valid_mem_i;
  logic             wr_en_mem_i;
  logic [4:0]       rd_mem_i;
  logic [1:0]       wb_sel_mem_i;
  logic [2:0]       ld_funct3_mem_i;
  logic [31:0]      alu_res_mem_i;
  logic [31:0]      ld_data_mem_i;
  logic [31:0]      pc4_mem_i;
  logic             stall_wb_i;
  logic             flush_wb_i;

  logic             w_en_rf_o;
  logic [4:0]       w_reg_rf_o;
  logic [31:0]      w_data_rf_o;
  logic             fwd_vld_o;
  logic             retire_o;
  logic             ld_err_o;
  logic [CNT_W-1:0] instret_o;

  modport master (
    output valid_mem_i, wr_en_mem_i, rd_mem_i, wb_sel_mem_i, ld_funct3_mem_i,
           alu_res_mem_i, ld_data_mem_i, pc4_mem_i, stall_wb_i, flush_wb_i,
    input  w_en_rf_o, w_reg_rf_o, w_data_rf_o, fwd_vld_o, retire_o, ld_err_o,
           instret_o
  );

  modport slave (
    input  valid_mem_i, wr_en_mem_i, rd_mem_i, wb_sel_mem_i, ld_funct3_mem_i,
           alu_res_mem_i, ld_data_mem_i, pc4_mem_i, stall_wb_i, flush_wb_i,
    output w_en_rf_o, w_reg_rf_o, w_data_rf_o, fwd_vld_o, retire_o, ld_err_o,
           instret_o
  );
endinterface

// File: rtl/wb_stage_ld_align.sv
// -----------------------------------------------------------------------------
// ld_align
// Combinational load formatter: picks the addressed byte/half out of an aligned
// data word and sign- or zero-extends it.
//   funct3 : load size/sign (lb, lh, lw, lbu, lhu)
//   off    : byte offset within the word
//   word   : raw aligned data word
//   data   : formatted load value
//   err    : misaligned access or reserved funct3 (3, 6, 7)
// -----------------------------------------------------------------------------
module ld_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        err
);

  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign byte_lane[gi] = word[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign half_lane[gi] = word[16*gi +: 16];
    end
  endgenerate

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = byte_lane[off];
    sel_half = half_lane[off[1]];
    data     = '0;
    err      = 1'b0;
    case (funct3)
      F3_LB:   data = {{24{sel_byte[7]}}, sel_byte};
      F3_LBU:  data = {24'd0, sel_byte};
      F3_LH: begin
        data = {{16{sel_half[15]}}, sel_half};
        err  = off[0];
      end
      F3_LHU: begin
        data = {16'd0, sel_half};
        err  = off[0];
      end
      F3_LW: begin
        data = word;
        err  = |off;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// MEM/WB pipeline register plus writeback formatter feeding the 32x32 regfile
// (written on negedge clk) and the EX forwarding path.
//   clk   : pipeline clock
//   reset : asynchronous, active-low
//   bus   : wb_stage_if.slave (MEM inputs, stall/flush, regfile/forward/retire
//           outputs, retired-instruction count)
// Optional feature: define WB_RETIRE_CNT_EN to build the CNT_W-bit retire
// counter; otherwise instret_o is tied to 0 and no counter flops exist.
// -----------------------------------------------------------------------------
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 64
) (
  input  logic      clk,
  input  logic      reset,
  wb_stage_if.slave bus
);

  wb_slot_t slot_reg, slot_next;
  // fired_reg: the instruction in the slot has already been presented once, so
  // repeats while stalled must not write or retire again.
  logic     fired_reg, fired_next;

  always_comb begin
    slot_next  = slot_reg;
    fired_next = fired_reg;
    if (bus.flush_wb_i) begin
      slot_next.valid = 1'b0;
    end else if (!bus.stall_wb_i) begin
      slot_next.valid     = bus.valid_mem_i;
      slot_next.wr_en     = bus.wr_en_mem_i;
      slot_next.rd        = bus.rd_mem_i;
      slot_next.wb_sel    = bus.wb_sel_mem_i;
      slot_next.ld_funct3 = bus.ld_funct3_mem_i;
      slot_next.alu_res   = bus.alu_res_mem_i;
      slot_next.ld_data   = bus.ld_data_mem_i;
      slot_next.pc4       = bus.pc4_mem_i;
      fired_next          = 1'b0;
    end else begin
      fired_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_reg  <= '0;
      fired_reg <= 1'b0;
    end else begin
      slot_reg  <= slot_next;
      fired_reg <= fired_next;
    end
  end

  logic [XLEN-1:0] ld_fmt;
  logic            ld_bad;

  ld_align u_ld_align (
    .funct3 (slot_reg.ld_funct3),
    .off    (slot_reg.alu_res[1:0]),
    .word   (slot_reg.ld_data),
    .data   (ld_fmt),
    .err    (ld_bad)
  );

  logic            is_load;
  logic            err;
  logic            first;
  logic            wq;
  logic            w_en;
  logic [XLEN-1:0] sel_data;

  always_comb begin
    is_load = (slot_reg.wb_sel == WB_SEL_LOAD);
    // Alignment/funct3 faults only matter when the load path is selected.
    err     = is_load & ld_bad;
    first   = slot_reg.valid & ~fired_reg;
    wq      = slot_reg.valid & slot_reg.wr_en & (|slot_reg.rd) & ~err &
              (slot_reg.wb_sel != WB_SEL_RSVD);
    w_en    = wq & ~fired_reg;
    case (slot_reg.wb_sel)
      WB_SEL_ALU:  sel_data = slot_reg.alu_res;
      WB_SEL_LOAD: sel_data = ld_fmt;
      WB_SEL_PC4:  sel_data = slot_reg.pc4;
      default:     sel_data = '0;
    endcase
  end

  assign bus.w_en_rf_o   = w_en;
  assign bus.w_reg_rf_o  = w_en ? slot_reg.rd : 5'd0;
  assign bus.w_data_rf_o = w_en ? sel_data : '0;
  assign bus.fwd_vld_o   = wq;
  assign bus.retire_o    = first;
  assign bus.ld_err_o    = first & err;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Wraps to 0 naturally from all-ones.
  always_comb begin
    cnt_next = cnt_reg;
    if (first) cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_reg <= '0;
    else        cnt_reg <= cnt_next;
  end

  assign bus.instret_o = cnt_reg;
`else
  assign bus.instret_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  localparam int CNT_W = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wb_stage_if #(.CNT_W(CNT_W)) bus ();

  wb_stage #(.XLEN(32), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_cnt = '0;

  typedef struct packed {
    logic        valid;
    logic        wr;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] pc4;
  } slot_t;

  typedef struct {
    string       name;
    slot_t       s;
    logic        e_wen;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic        e_fwd;
    logic        e_ret;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(string nm, logic v, logic wr, logic [4:0] rd,
                              logic [1:0] sel, logic [2:0] f3, logic [31:0] alu,
                              logic [31:0] ld, logic [31:0] pc4, logic ewen,
                              logic [4:0] ereg, logic [31:0] edata, logic efwd,
                              logic eret, logic eerr);
    vec_t r;
    r.name = nm;
    r.s = '{valid: v, wr: wr, rd: rd, sel: sel, f3: f3, alu: alu, ld: ld, pc4: pc4};
    r.e_wen = ewen; r.e_reg = ereg; r.e_data = edata;
    r.e_fwd = efwd; r.e_ret = eret; r.e_err = eerr;
    return r;
  endfunction

  task automatic drive(slot_t s, logic stall, logic flush);
    bus.valid_mem_i     = s.valid;
    bus.wr_en_mem_i     = s.wr;
    bus.rd_mem_i        = s.rd;
    bus.wb_sel_mem_i    = s.sel;
    bus.ld_funct3_mem_i = s.f3;
    bus.alu_res_mem_i   = s.alu;
    bus.ld_data_mem_i   = s.ld;
    bus.pc4_mem_i       = s.pc4;
    bus.stall_wb_i      = stall;
    bus.flush_wb_i      = flush;
  endtask

  task automatic chk(string nm, string field, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h want %0h", nm, field, act, exp);
    end
  endtask

  // Compares every output once; the retire expectation also advances the
  // expected retire count, which the DUT shows from the following cycle on.
  task automatic check_all(string nm, logic ewen, logic [4:0] ereg, logic [31:0] edata,
                           logic efwd, logic eret, logic eerr);
    logic [63:0] ecnt;
`ifdef WB_RETIRE_CNT_EN
    ecnt = exp_cnt;
`else
    ecnt = '0;
`endif
    chk(nm, "w_en",    {63'd0, bus.w_en_rf_o}, {63'd0, ewen});
    chk(nm, "w_reg",   {59'd0, bus.w_reg_rf_o}, {59'd0, ereg});
    chk(nm, "w_data",  {32'd0, bus.w_data_rf_o}, {32'd0, edata});
    chk(nm, "fwd_vld", {63'd0, bus.fwd_vld_o}, {63'd0, efwd});
    chk(nm, "retire",  {63'd0, bus.retire_o}, {63'd0, eret});
    chk(nm, "ld_err",  {63'd0, bus.ld_err_o}, {63'd0, eerr});
    chk(nm, "instret", bus.instret_o, ecnt);
    if (eret) exp_cnt = exp_cnt + 64'd1;
    $display("txn %s: wen=%0b reg=%0d data=%08h fwd=%0b ret=%0b err=%0b cnt=%0d",
             nm, bus.w_en_rf_o, bus.w_reg_rf_o, bus.w_data_rf_o, bus.fwd_vld_o,
             bus.retire_o, bus.ld_err_o, bus.instret_o);
  endtask

  // Reference: format a load by shifting/masking the word and extending with
  // plain arithmetic.
  task automatic load_fmt(logic [2:0] f3, logic [1:0] off, logic [31:0] word,
                          output logic [31:0] v, output logic bad);
    int o;
    o = int'(off);
    bad = 1'b0;
    v = '0;
    case (f3)
      3'd0, 3'd4: begin
        v = (word >> (8 * o)) & 32'h0000_00FF;
        if (f3 == 3'd0 && v >= 32'h80) v = v - 32'h100;
      end
      3'd1, 3'd5: begin
        bad = (o % 2) != 0;
        v = (word >> (16 * (o / 2))) & 32'h0000_FFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h1_0000;
      end
      3'd2: begin
        bad = (o != 0);
        v = word;
      end
      default: bad = 1'b1;
    endcase
  endtask

  task automatic model_check(string nm, slot_t s, bit rep);
    logic [31:0] val;
    logic bad, wants;
    val = '0;
    bad = 1'b0;
    case (s.sel)
      2'd0: val = s.alu;
      2'd1: load_fmt(s.f3, s.alu[1:0], s.ld, val, bad);
      2'd2: val = s.pc4;
      default: val = '0;
    endcase
    wants = s.valid && s.wr && (s.rd != 5'd0) && !bad && (s.sel != 2'd3);
    check_all(nm, wants && !rep, (wants && !rep) ? s.rd : 5'd0,
              (wants && !rep) ? val : 32'd0, wants, s.valid && !rep,
              s.valid && !rep && bad);
  endtask

  vec_t  vecs[14];
  slot_t idle;
  slot_t t;
  slot_t m_slot;
  bit    m_rep;

  initial begin
    idle = '0;
    drive(idle, 1'b0, 1'b0);

    vecs[0]  = mk("alu_rd5",   1,1,5'd5, 2'd0,3'd0,32'h1234_5678,32'h0,32'h0,        1,5'd5, 32'h1234_5678,1,1,0);
    vecs[1]  = mk("lb_off3",   1,1,5'd2, 2'd1,3'd0,32'h0000_0003,32'h80FF_0000,32'h0, 1,5'd2, 32'hFFFF_FF80,1,1,0);
    vecs[2]  = mk("lbu_off3",  1,1,5'd2, 2'd1,3'd4,32'h0000_0003,32'h80FF_0000,32'h0, 1,5'd2, 32'h0000_0080,1,1,0);
    vecs[3]  = mk("lhu_off2",  1,1,5'd3, 2'd1,3'd5,32'h0000_0002,32'h80FF_0000,32'h0, 1,5'd3, 32'h0000_80FF,1,1,0);
    vecs[4]  = mk("lw_off2",   1,1,5'd4, 2'd1,3'd2,32'h0000_0002,32'h80FF_0000,32'h0, 0,5'd0, 32'h0,        0,1,1);
    vecs[5]  = mk("lh_off1",   1,1,5'd4, 2'd1,3'd1,32'h0000_0001,32'h80FF_0000,32'h0, 0,5'd0, 32'h0,        0,1,1);
    vecs[6]  = mk("f3_rsvd3",  1,1,5'd4, 2'd1,3'd3,32'h0000_0000,32'h80FF_0000,32'h0, 0,5'd0, 32'h0,        0,1,1);
    vecs[7]  = mk("rd0",       1,1,5'd0, 2'd0,3'd0,32'hDEAD_BEEF,32'h0,32'h0,        0,5'd0, 32'h0,        0,1,0);
    vecs[8]  = mk("sel_rsvd",  1,1,5'd6, 2'd3,3'd0,32'hDEAD_BEEF,32'h0,32'h44,       0,5'd0, 32'h0,        0,1,0);
    vecs[9]  = mk("bubble",    0,1,5'd5, 2'd0,3'd0,32'hDEAD_BEEF,32'h0,32'h0,        0,5'd0, 32'h0,        0,0,0);
    vecs[10] = mk("nowr_lwerr",1,0,5'd7, 2'd1,3'd2,32'h0000_0001,32'h1111_2222,32'h0, 0,5'd0, 32'h0,        0,1,1);
    vecs[11] = mk("lh_off2",   1,1,5'd9, 2'd1,3'd1,32'h0000_0002,32'h80FF_0000,32'h0, 1,5'd9, 32'hFFFF_80FF,1,1,0);
    vecs[12] = mk("pc4_rd31",  1,1,5'd31,2'd2,3'd0,32'h0000_0001,32'h0,32'h0000_0200,1,5'd31,32'h0000_0200,1,1,0);
    vecs[13] = mk("lw_off0",   1,1,5'd8, 2'd1,3'd2,32'h0000_1000,32'h80FF_0000,32'h0, 1,5'd8, 32'h80FF_0000,1,1,0);

    // Reset asserted, then the first cycle after release.
    #12;
    check_all("reset_held", 0, 5'd0, 32'd0, 0, 0, 0);
    reset = 1'b1;
    #1;
    check_all("reset_release", 0, 5'd0, 32'd0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].s, 1'b0, 1'b0);
      @(posedge clk); #1;
      check_all(vecs[i].name, vecs[i].e_wen, vecs[i].e_reg, vecs[i].e_data,
                vecs[i].e_fwd, vecs[i].e_ret, vecs[i].e_err);
    end

    // PC+4 write held by a 3-cycle stall; inputs change to prove the hold.
    t = '{valid:1, wr:1, rd:5'd1, sel:2'd2, f3:3'd0, alu:32'h0, ld:32'h0, pc4:32'h0000_0104};
    drive(t, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("stall_first", 1, 5'd1, 32'h104, 1, 1, 0);
    t = '{valid:1, wr:1, rd:5'd9, sel:2'd0, f3:3'd0, alu:32'hAAAA_0000, ld:32'h0, pc4:32'h0};
    for (int k = 0; k < 3; k++) begin
      drive(t, 1'b1, 1'b0);
      @(posedge clk); #1;
      check_all($sformatf("stall_hold%0d", k), 0, 5'd0, 32'd0, 1, 0, 0);
    end
    drive(idle, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("stall_release", 0, 5'd0, 32'd0, 0, 0, 0);

    // Flush wins over stall.
    t = '{valid:1, wr:1, rd:5'd3, sel:2'd0, f3:3'd0, alu:32'h0000_0033, ld:32'h0, pc4:32'h0};
    drive(t, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("pre_flush", 1, 5'd3, 32'h33, 1, 1, 0);
    drive(t, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_all("flush_stall", 0, 5'd0, 32'd0, 0, 0, 0);
    drive(idle, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("post_flush", 0, 5'd0, 32'd0, 0, 0, 0);

    // Randomized traffic against the reference model.
    m_slot = '0;
    m_rep  = 1'b0;
    for (int n = 0; n < 300; n++) begin
      logic st, fl;
      t.valid = ($urandom_range(0, 9) < 8);
      t.wr    = ($urandom_range(0, 9) < 8);
      t.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      t.sel   = 2'($urandom_range(0, 3));
      t.f3    = 3'($urandom_range(0, 7));
      t.alu   = $urandom;
      t.ld    = $urandom;
      t.pc4   = $urandom;
      st      = ($urandom_range(0, 9) < 3);
      fl      = ($urandom_range(0, 9) == 0);
      drive(t, st, fl);
      @(posedge clk);
      if (fl) m_slot.valid = 1'b0;
      else if (!st) begin m_slot = t; m_rep = 1'b0; end
      else m_rep = 1'b1;
      #1;
      model_check($sformatf("rnd%0d", n), m_slot, m_rep);
    end

    // Reset asserted in the middle of a stalled cycle.
    t = '{valid:1, wr:1, rd:5'd7, sel:2'd0, f3:3'd0, alu:32'h0000_0777, ld:32'h0, pc4:32'h0};
    drive(t, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("rst_pre", 1, 5'd7, 32'h777, 1, 1, 0);
    drive(t, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_all("rst_stalled", 0, 5'd0, 32'd0, 1, 0, 0);
    #2;
    reset = 1'b0;
    exp_cnt = '0;
    #1;
    check_all("rst_mid_stall", 0, 5'd0, 32'd0, 0, 0, 0);
    #2;
    reset = 1'b1;
    drive(idle, 1'b0, 1'b0);
    #1;
    check_all("rst_released", 0, 5'd0, 32'd0, 0, 0, 0);
    @(posedge clk); #1;
    check_all("rst_idle", 0, 5'd0, 32'd0, 0, 0, 0);

`ifdef WB_RETIRE_CNT_EN
    // Counter wrap from all-ones.
    dut.cnt_reg = '1;
    exp_cnt = '1;
    t = '{valid:1, wr:1, rd:5'd2, sel:2'd0, f3:3'd0, alu:32'h0000_0002, ld:32'h0, pc4:32'h0};
    drive(t, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("cnt_allones", 1, 5'd2, 32'h2, 1, 1, 0);
    drive(idle, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_all("cnt_wrapped", 0, 5'd0, 32'd0, 0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
